// File: rtl/ritc_align_sequencer.sv
// Walks all 72 RITC data lanes: sweeps IDELAY taps to find the widest stable eye,
// loads its centre, then bitslips until the training nibble lines up. Idle = host pass-through.
module ritc_align_sequencer #(
  parameter int         NTAPS   = 32,
  parameter int         SETTLE  = 8,
  parameter int         SAMPLES = 16,
  parameter int         MIN_EYE = 4,
  parameter logic [3:0] PATTERN = 4'b1010
) (
  input  logic        user_clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        fail_o,
  output logic        train_o,
  output logic [2:0]  lane_chan_o,
  output logic [3:0]  lane_bit_o,
  input  logic [3:0]  cap_i,
  input  logic        cap_valid_i,
  output logic [4:0]  lane_tap_o,
  output logic [1:0]  lane_slip_o,
  output logic        lane_valid_o,
  input  logic        host_sel_i,
  input  logic        host_wr_i,
  input  logic        host_rd_i,
  input  logic [3:0]  host_addr_i,
  input  logic [31:0] host_dat_i,
  output logic [31:0] host_dat_o,
  output logic        dp_sel_o,
  output logic        dp_wr_o,
  output logic        dp_rd_o,
  output logic [3:0]  dp_addr_o,
  output logic [31:0] dp_dat_o,
  input  logic [31:0] dp_dat_i
);

  localparam int SETTLE_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int SAMP_W   = (SAMPLES > 1) ? $clog2(SAMPLES) : 1;
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE - 1);
  localparam logic [SAMP_W-1:0]   SAMP_LAST   = SAMP_W'(SAMPLES - 1);
  localparam logic [4:0] TAP_LAST  = 5'(NTAPS - 1);
  localparam logic [4:0] MIN_EYE_L = 5'(MIN_EYE);
  localparam logic [4:0] LEN_MAX   = 5'd31;
  localparam logic [3:0] ADDR_SLIP = 4'h1;
  localparam logic [3:0] ADDR_TAP  = 4'h2;
  localparam logic [3:0] ADDR_CTRL = 4'h3;
  localparam logic [7:0] PAT2      = {PATTERN, PATTERN};

  typedef enum logic [3:0] {
    S_IDLE, S_TRAIN, S_WR_TAP, S_WR_LOAD, S_SETTLE, S_SAMPLE, S_EVAL, S_WR_CTR,
    S_WR_CTR_LOAD, S_SETTLE2, S_CHECK, S_SLIP, S_NEXT_LANE, S_DONE, S_FAIL
  } state_t;

  state_t                state_reg, state_next;
  logic [SETTLE_W-1:0]   settle_cnt_reg;
  logic [SAMP_W-1:0]     samp_cnt_reg;
  logic [3:0]            first_cap_reg;
  logic                  same_reg;
  logic [4:0]            tap_reg;
  logic [4:0]            cur_start_reg, cur_len_reg;
  logic [4:0]            best_start_reg, best_len_reg;
  logic [1:0]            slip_cnt_reg;
  logic [2:0]            chan_reg;
  logic [3:0]            bit_reg;
  logic [4:0]            lane_tap_reg;
  logic [1:0]            lane_slip_reg;

  logic [3:0]  rot_hit;
  logic        tap_good;
  logic [4:0]  cur_len_inc, run_start, best_len_eval, centre_tap;
  logic        last_lane, settle_done, eval_better;
  logic        seq_wr;
  logic [3:0]  seq_addr;
  logic [31:0] seq_dat;

  // A tap is good only if every capture matched the first and that value is a PATTERN rotation.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_rot
      assign rot_hit[gi] = (first_cap_reg == PAT2[gi +: 4]);
    end
  endgenerate

  // Run lengths saturate at 31 so a full 32-tap eye still centres inside the 5-bit tap range.
  assign tap_good      = same_reg & (|rot_hit);
  assign cur_len_inc   = (cur_len_reg == LEN_MAX) ? LEN_MAX : cur_len_reg + 5'd1;
  assign run_start     = (cur_len_reg == 5'd0) ? tap_reg : cur_start_reg;
  assign eval_better   = tap_good && (cur_len_inc > best_len_reg);
  assign best_len_eval = eval_better ? cur_len_inc : best_len_reg;
  assign centre_tap    = best_start_reg + {1'b0, best_len_reg[4:1]};
  assign last_lane     = (chan_reg == 3'd5) && (bit_reg == 4'd11);
  assign settle_done   = (settle_cnt_reg == SETTLE_LAST);

  always_comb begin
    state_next = state_reg;
    seq_wr     = 1'b0;
    seq_addr   = 4'h0;
    seq_dat    = 32'h0;
    case (state_reg)
      S_IDLE:    if (start_i) state_next = S_TRAIN;
      S_TRAIN:   if (settle_done) state_next = S_WR_TAP;
      S_WR_TAP: begin
        seq_wr     = 1'b1;
        seq_addr   = ADDR_TAP;
        seq_dat    = {13'b0, chan_reg, 4'b0, bit_reg, 3'b0, tap_reg};
        state_next = S_WR_LOAD;
      end
      S_WR_LOAD: begin
        seq_wr     = 1'b1;
        seq_addr   = ADDR_CTRL;
        seq_dat    = 32'h1;
        state_next = S_SETTLE;
      end
      S_SETTLE:  if (settle_done) state_next = S_SAMPLE;
      S_SAMPLE:  if (cap_valid_i && samp_cnt_reg == SAMP_LAST) state_next = S_EVAL;
      S_EVAL: begin
        if (tap_reg != TAP_LAST) state_next = S_WR_TAP;
        else if (best_len_eval < MIN_EYE_L) state_next = S_FAIL;
        else state_next = S_WR_CTR;
      end
      S_WR_CTR: begin
        seq_wr     = 1'b1;
        seq_addr   = ADDR_TAP;
        seq_dat    = {13'b0, chan_reg, 4'b0, bit_reg, 3'b0, centre_tap};
        state_next = S_WR_CTR_LOAD;
      end
      S_WR_CTR_LOAD: begin
        seq_wr     = 1'b1;
        seq_addr   = ADDR_CTRL;
        seq_dat    = 32'h1;
        state_next = S_SETTLE2;
      end
      S_SETTLE2: if (settle_done) state_next = S_CHECK;
      S_CHECK: begin
        if (cap_valid_i) begin
          if (cap_i == PATTERN) state_next = S_NEXT_LANE;
          else if (slip_cnt_reg == 2'd3) state_next = S_FAIL;
          else state_next = S_SLIP;
        end
      end
      S_SLIP: begin
        seq_wr     = 1'b1;
        seq_addr   = ADDR_SLIP;
        seq_dat    = {1'b1, 12'b0, chan_reg, 4'b0, bit_reg, 8'b0};
        state_next = S_SETTLE2;
      end
      S_NEXT_LANE: state_next = last_lane ? S_DONE : S_WR_TAP;
      S_DONE:      state_next = S_IDLE;
      S_FAIL:      state_next = S_IDLE;
      default:     state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge user_clk_i) begin
    if (rst_i) begin
      state_reg      <= S_IDLE;
      settle_cnt_reg <= '0;
      samp_cnt_reg   <= '0;
      first_cap_reg  <= 4'h0;
      same_reg       <= 1'b0;
      tap_reg        <= 5'd0;
      cur_start_reg  <= 5'd0;
      cur_len_reg    <= 5'd0;
      best_start_reg <= 5'd0;
      best_len_reg   <= 5'd0;
      slip_cnt_reg   <= 2'd0;
      chan_reg       <= 3'd0;
      bit_reg        <= 4'd0;
      lane_tap_reg   <= 5'd0;
      lane_slip_reg  <= 2'd0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        S_IDLE: begin
          if (start_i) begin
            chan_reg       <= 3'd0;
            bit_reg        <= 4'd0;
            tap_reg        <= 5'd0;
            cur_start_reg  <= 5'd0;
            cur_len_reg    <= 5'd0;
            best_start_reg <= 5'd0;
            best_len_reg   <= 5'd0;
            slip_cnt_reg   <= 2'd0;
            settle_cnt_reg <= '0;
            samp_cnt_reg   <= '0;
          end
        end
        S_TRAIN, S_SETTLE, S_SETTLE2: begin
          settle_cnt_reg <= settle_done ? '0 : settle_cnt_reg + 1'b1;
        end
        S_SAMPLE: begin
          if (cap_valid_i) begin
            samp_cnt_reg <= (samp_cnt_reg == SAMP_LAST) ? '0 : samp_cnt_reg + 1'b1;
            if (samp_cnt_reg == '0) begin
              first_cap_reg <= cap_i;
              same_reg      <= 1'b1;
            end else begin
              same_reg <= same_reg & (cap_i == first_cap_reg);
            end
          end
        end
        S_EVAL: begin
          // Strict '>' keeps the earliest run on equal lengths.
          if (tap_good) begin
            cur_start_reg <= run_start;
            cur_len_reg   <= cur_len_inc;
            if (eval_better) begin
              best_start_reg <= run_start;
              best_len_reg   <= cur_len_inc;
            end
          end else begin
            cur_len_reg <= 5'd0;
          end
          if (tap_reg != TAP_LAST) tap_reg <= tap_reg + 5'd1;
        end
        S_CHECK: begin
          if (cap_valid_i && cap_i == PATTERN) begin
            lane_tap_reg  <= centre_tap;
            lane_slip_reg <= slip_cnt_reg;
          end
        end
        S_SLIP: slip_cnt_reg <= slip_cnt_reg + 2'd1;
        S_NEXT_LANE: begin
          if (!last_lane) begin
            if (bit_reg == 4'd11) begin
              bit_reg  <= 4'd0;
              chan_reg <= chan_reg + 3'd1;
            end else begin
              bit_reg <= bit_reg + 4'd1;
            end
          end
          tap_reg        <= 5'd0;
          cur_start_reg  <= 5'd0;
          cur_len_reg    <= 5'd0;
          best_start_reg <= 5'd0;
          best_len_reg   <= 5'd0;
          slip_cnt_reg   <= 2'd0;
        end
        default: ;
      endcase
    end
  end

  assign busy_o       = (state_reg != S_IDLE) && (state_reg != S_DONE) && (state_reg != S_FAIL);
  assign train_o      = busy_o;
  assign done_o       = (state_reg == S_DONE);
  assign fail_o       = (state_reg == S_FAIL);
  assign lane_valid_o = (state_reg == S_NEXT_LANE);
  assign lane_chan_o  = chan_reg;
  assign lane_bit_o   = bit_reg;
  assign lane_tap_o   = lane_tap_reg;
  assign lane_slip_o  = lane_slip_reg;

  // The sequencer owns the datapath port while busy; host traffic is dropped then.
  assign dp_sel_o   = busy_o ? seq_wr   : host_sel_i;
  assign dp_wr_o    = busy_o ? seq_wr   : host_wr_i;
  assign dp_rd_o    = busy_o ? 1'b0     : host_rd_i;
  assign dp_addr_o  = busy_o ? seq_addr : host_addr_i;
  assign dp_dat_o   = busy_o ? seq_dat  : host_dat_i;
  assign host_dat_o = busy_o ? {16'hA11C, 9'b0, chan_reg, bit_reg} : dp_dat_i;

endmodule
